// File: rtl/fht_loader_pkg.sv
// Shared types and helpers for the ADC-to-FHT frame loader.
package fht_loader_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

    localparam int N_POINT_DEF = 1024;
    localparam int LOG2_N      = $clog2(N_POINT_DEF);

    // Mirrors the low nbits of k; bits above nbits come back as zero.
    function automatic logic [31:0] rev(input logic [31:0] k, input int nbits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) r[nbits-1-i] = k[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_adc_loader_if.sv
// Bus between the ADC loader, the ADC source and fht_top's input banks.
interface fht_adc_loader_if #(
    parameter int ADC_BIT = 15,
    parameter int A_BIT   = 8
);
    logic                      iEN;
    logic signed [ADC_BIT-1:0] iADC_DATA;
    logic                      iADC_VALID;
    logic                      oADC_READY;
    logic signed [ADC_BIT-1:0] oDATA;
    logic [A_BIT-1:0]          oADDR_WR;
    logic [3:0]                oWE;
    logic                      oSTART;
    logic                      iFHT_RDY;
    logic                      oBUSY;
    logic                      oOVF;

    modport master (
        input  iEN, iADC_DATA, iADC_VALID, iFHT_RDY,
        output oADC_READY, oDATA, oADDR_WR, oWE, oSTART, oBUSY, oOVF
    );

    modport slave (
        output iEN, iADC_DATA, iADC_VALID, iFHT_RDY,
        input  oADC_READY, oDATA, oADDR_WR, oWE, oSTART, oBUSY, oOVF
    );
endinterface

// File: rtl/fht_bank_addr_gen.sv
// Maps sample index k to a bank one-hot and bank address, registered one cycle.
module fht_bank_addr_gen
    import fht_loader_pkg::*;
#(
    parameter int A_BIT  = 8,
    parameter int BITREV = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [A_BIT+1:0]   k,
    input  logic               wr,
    output logic [3:0]         we,
    output logic [A_BIT-1:0]   addr
);
    localparam int LG_N = A_BIT + 2;

    logic [LG_N-1:0] p;

    // NOTE: p gets a value on every path before any condition, so no latch is inferred.
    always_comb begin
        p = k;
        if (BITREV != 0) p = LG_N'(rev(32'(k), LG_N));
    end

    // The low two index bits select the bank, the rest form the bank address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we   <= '0;
            addr <= '0;
        end else begin
            we <= '0;
            if (wr) begin
                we   <= 4'b0001 << p[1:0];
                addr <= p[A_BIT+1:2];
            end
        end
    end

endmodule

// File: rtl/fht_adc_loader.sv
// Streams one N-point ADC frame into fht_top's banks, pulses iSTART, then waits for oRDY.
module fht_adc_loader
    import fht_loader_pkg::*;
#(
    parameter int ADC_BIT = 15,
    parameter int A_BIT   = 8,
    parameter int N_POINT = N_POINT_DEF,
    parameter int BITREV  = 0
) (
    input  logic              iCLK,
    input  logic              iRESET,
    fht_adc_loader_if.master  bus
);
    localparam int              LG_N   = A_BIT + 2;
    localparam logic [LG_N-1:0] K_LAST = LG_N'(N_POINT - 1);

    state_t          state;
    logic [LG_N-1:0] k;
    logic            gap_q;
    logic            rdy_q;
    logic            accept;

    assign accept = bus.iADC_VALID & bus.oADC_READY & (state == LOAD);

    fht_bank_addr_gen #(
        .A_BIT  (A_BIT),
        .BITREV (BITREV)
    ) u_addr_gen (
        .clk   (iCLK),
        .rst_n (iRESET),
        .k     (k),
        .wr    (accept),
        .we    (bus.oWE),
        .addr  (bus.oADDR_WR)
    );

    // NOTE: every register here updates with <=, so all reads see pre-edge values.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state          <= IDLE;
            k              <= '0;
            gap_q          <= 1'b0;
            rdy_q          <= 1'b0;
            bus.oADC_READY <= 1'b0;
            bus.oDATA      <= '0;
            bus.oSTART     <= 1'b0;
            bus.oBUSY      <= 1'b0;
            bus.oOVF       <= 1'b0;
        end else begin
            rdy_q      <= bus.iFHT_RDY;
            bus.oSTART <= 1'b0;
            bus.oOVF   <= bus.iEN & (bus.oOVF | (bus.iADC_VALID & ~bus.oADC_READY));
            if (accept) bus.oDATA <= ADC_BIT'(bus.iADC_DATA);

            unique case (state)
                IDLE: begin
                    k              <= '0;
                    bus.oBUSY      <= 1'b0;
                    bus.oADC_READY <= bus.iEN;
                    if (bus.iEN) state <= LOAD;
                end
                LOAD: begin
                    // A completed frame wins over a simultaneous disarm.
                    if (accept && k == K_LAST) begin
                        k              <= '0;
                        gap_q          <= 1'b0;
                        state          <= START;
                        bus.oADC_READY <= 1'b0;
                        bus.oBUSY      <= 1'b1;
                    end else if (!bus.iEN) begin
                        k              <= '0;
                        state          <= IDLE;
                        bus.oADC_READY <= 1'b0;
                        bus.oBUSY      <= 1'b0;
                    end else begin
                        bus.oADC_READY <= 1'b1;
                        if (accept) begin
                            k         <= k + 1'b1;
                            bus.oBUSY <= 1'b1;
                        end
                    end
                end
                START: begin
                    // First cycle is the gap after the final write strobe.
                    gap_q <= 1'b1;
                    if (gap_q) begin
                        bus.oSTART <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.iFHT_RDY && !rdy_q) begin
                        state          <= bus.iEN ? LOAD : IDLE;
                        bus.oADC_READY <= bus.iEN;
                        bus.oBUSY      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fht_adc_loader.sv
// Self-checking bench: natural and bit-reversed loaders driven side by side.
module tb_fht_adc_loader;
    import fht_loader_pkg::*;

    localparam int N  = N_POINT_DEF;
    localparam int LG = LOG2_N;

    typedef struct {
        logic [3:0]         we;
        logic [7:0]         addr;
        logic signed [14:0] data;
        int                 cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fht_adc_loader_if #(.ADC_BIT(15), .A_BIT(8)) bus_n ();
    fht_adc_loader_if #(.ADC_BIT(15), .A_BIT(8)) bus_r ();

    assign bus_r.iEN        = bus_n.iEN;
    assign bus_r.iADC_DATA  = bus_n.iADC_DATA;
    assign bus_r.iADC_VALID = bus_n.iADC_VALID;
    assign bus_r.iFHT_RDY   = bus_n.iFHT_RDY;

    fht_adc_loader #(.ADC_BIT(15), .A_BIT(8), .N_POINT(N), .BITREV(0)) u_nat (
        .iCLK(clk), .iRESET(rst_n), .bus(bus_n)
    );
    fht_adc_loader #(.ADC_BIT(15), .A_BIT(8), .N_POINT(N), .BITREV(1)) u_rev (
        .iCLK(clk), .iRESET(rst_n), .bus(bus_r)
    );

    wr_t                log0[$];
    wr_t                log1[$];
    logic signed [14:0] mem[2][N];
    int                 wcnt[2][N];
    int                 nstart[2];
    int                 start_cyc[2];
    int                 last_we_cyc[2];
    int                 bad_we[2];
    logic signed [14:0] sent[N];

    function automatic int idx_of(input logic [3:0] we, input logic [7:0] addr);
        int bank;
        bank = (we == 4'b0001) ? 0 : (we == 4'b0010) ? 1 : (we == 4'b0100) ? 2 : 3;
        return int'(addr) * 4 + bank;
    endfunction

    function automatic int brev(input int k, input int bits);
        int r = 0;
        int v = k;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // Bank write monitors: record what each loader presents to the RAMs.
    always @(negedge clk) begin
        if (bus_n.oWE != 4'b0000) begin
            wr_t w;
            int  i;
            if (!$onehot(bus_n.oWE)) bad_we[0]++;
            w = '{bus_n.oWE, bus_n.oADDR_WR, bus_n.oDATA, cyc};
            log0.push_back(w);
            i = idx_of(bus_n.oWE, bus_n.oADDR_WR);
            mem[0][i] = bus_n.oDATA;
            wcnt[0][i]++;
            last_we_cyc[0] = cyc;
        end
        if (bus_n.oSTART) begin
            nstart[0]++;
            start_cyc[0] = cyc;
        end
    end

    always @(negedge clk) begin
        if (bus_r.oWE != 4'b0000) begin
            wr_t w;
            int  i;
            if (!$onehot(bus_r.oWE)) bad_we[1]++;
            w = '{bus_r.oWE, bus_r.oADDR_WR, bus_r.oDATA, cyc};
            log1.push_back(w);
            i = idx_of(bus_r.oWE, bus_r.oADDR_WR);
            mem[1][i] = bus_r.oDATA;
            wcnt[1][i]++;
            last_we_cyc[1] = cyc;
        end
        if (bus_r.oSTART) begin
            nstart[1]++;
            start_cyc[1] = cyc;
        end
    end

    task automatic clear_logs();
        log0.delete();
        log1.delete();
        for (int i = 0; i < N; i++) begin
            wcnt[0][i] = 0;
            wcnt[1][i] = 0;
        end
    endtask

    // Expected bank image: sample k lives at index k (natural) or rev(k), each written once.
    function automatic int image_errs(input int d, input int n);
        logic signed [14:0] expv[N];
        bit                 has[N];
        int                 bad = 0;
        int                 p;
        for (int i = 0; i < N; i++) has[i] = 1'b0;
        for (int k = 0; k < n; k++) begin
            p = (d == 1) ? brev(k, LG) : k;
            expv[p] = sent[k];
            has[p]  = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (has[i]) begin
                if (wcnt[d][i] != 1 || mem[d][i] !== expv[i]) bad++;
            end else if (wcnt[d][i] != 0) begin
                bad++;
            end
        end
        return bad + bad_we[d];
    endfunction

    task automatic drive_frame(input int n, input bit ramp);
        int                 k = 0;
        int                 idle = 0;
        logic signed [14:0] v;
        while (k < n) begin
            @(negedge clk);
            if (bus_n.oADC_READY) begin
                v = ramp ? 15'(k - 512) : 15'($urandom);
                bus_n.iADC_DATA  = v;
                bus_n.iADC_VALID = 1'b1;
                sent[k] = v;
                k++;
                idle = 0;
            end else begin
                bus_n.iADC_VALID = 1'b0;
                idle++;
                if (idle > 100) begin
                    checks++;
                    errors++;
                    $display("FAIL drive_frame: ready low %0d cycles after %0d samples, required high", idle, k);
                    break;
                end
            end
        end
        @(negedge clk);
        bus_n.iADC_VALID = 1'b0;
    endtask

    task automatic wait_start(input int base);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (nstart[0] > base) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_start: no oSTART within 30 cycles (count %0d, required > %0d)", nstart[0], base);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 6 && !bus_n.oADC_READY; i++) @(negedge clk);
        checks++;
        if (bus_n.oADC_READY !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: oADC_READY=%b, required 1", bus_n.oADC_READY);
        end
    endtask

    task automatic test_reset();
        logic [30:0] obs_n, obs_r;
        repeat (3) @(negedge clk);
        obs_n = {bus_n.oADC_READY, bus_n.oWE, bus_n.oADDR_WR, bus_n.oDATA, bus_n.oSTART, bus_n.oBUSY, bus_n.oOVF};
        obs_r = {bus_r.oADC_READY, bus_r.oWE, bus_r.oADDR_WR, bus_r.oDATA, bus_r.oSTART, bus_r.oBUSY, bus_r.oOVF};
        checks++;
        if (obs_n !== 31'd0) begin
            errors++;
            $display("FAIL reset_nat: outputs=%h, required 0", obs_n);
        end
        checks++;
        if (obs_r !== 31'd0) begin
            errors++;
            $display("FAIL reset_rev: outputs=%h, required 0", obs_r);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (bus_n.oADC_READY !== 1'b0 || bus_r.oADC_READY !== 1'b0) begin
            errors++;
            $display("FAIL idle_disarmed: ready=%b/%b, required 0/0", bus_n.oADC_READY, bus_r.oADC_READY);
        end
    endtask

    task automatic test_natural_and_bitrev();
        int e;
        bus_n.iEN = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_n.oADC_READY !== 1'b1 || bus_n.oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL arm: ready=%b busy=%b, required ready=1 busy=0", bus_n.oADC_READY, bus_n.oBUSY);
        end
        clear_logs();
        drive_frame(N, 1'b1);
        wait_start(0);
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (log0.size() != N || log1.size() != N) begin
            errors++;
            $display("FAIL nat_count: writes=%0d/%0d, required %0d", log0.size(), log1.size(), N);
        end
        checks++;
        if (log0[5].we !== 4'b0010 || log0[5].addr !== 8'd1 || int'(log0[5].data) != -507) begin
            errors++;
            $display("FAIL nat_sample5: we=%b addr=%0d data=%0d, required we=0010 addr=1 data=-507",
                     log0[5].we, log0[5].addr, int'(log0[5].data));
        end
        checks++;
        if (log0[1023].we !== 4'b1000 || log0[1023].addr !== 8'd255) begin
            errors++;
            $display("FAIL nat_sample1023: we=%b addr=%0d, required we=1000 addr=255", log0[1023].we, log0[1023].addr);
        end
        checks++;
        if (nstart[0] != 1 || nstart[1] != 1) begin
            errors++;
            $display("FAIL start_count: %0d/%0d, required 1/1", nstart[0], nstart[1]);
        end
        checks++;
        if (start_cyc[0] - last_we_cyc[0] != 2) begin
            errors++;
            $display("FAIL start_gap: %0d cycles after last write, required 2", start_cyc[0] - last_we_cyc[0]);
        end
        checks++;
        if (log1[1].we !== 4'b0001 || log1[1].addr !== 8'd128) begin
            errors++;
            $display("FAIL rev_sample1: we=%b addr=%0d, required we=0001 addr=128", log1[1].we, log1[1].addr);
        end
        checks++;
        if (log1[3].we !== 4'b0001 || log1[3].addr !== 8'd192) begin
            errors++;
            $display("FAIL rev_sample3: we=%b addr=%0d, required we=0001 addr=192", log1[3].we, log1[3].addr);
        end
        for (int d = 0; d < 2; d++) begin
            e = image_errs(d, N);
            checks++;
            if (e != 0) begin
                errors++;
                $display("FAIL image_first dut%0d: %0d bad locations, required 0", d, e);
            end
        end
        checks++;
        if (bus_n.oBUSY !== 1'b1 || bus_n.oADC_READY !== 1'b0) begin
            errors++;
            $display("FAIL wait_state: busy=%b ready=%b, required busy=1 ready=0", bus_n.oBUSY, bus_n.oADC_READY);
        end
    endtask

    task automatic test_handshake();
        int n0, n1, ready_hi, e, base;
        n0 = log0.size();
        n1 = log1.size();
        ready_hi = 0;
        repeat (500) begin
            @(negedge clk);
            if (bus_n.oADC_READY || bus_r.oADC_READY) ready_hi++;
            bus_n.iADC_DATA  = 15'($urandom);
            bus_n.iADC_VALID = 1'b1;
        end
        @(negedge clk);
        bus_n.iADC_VALID = 1'b0;
        #1;
        checks++;
        if (ready_hi != 0) begin
            errors++;
            $display("FAIL hold_ready: oADC_READY high in %0d cycles, required 0", ready_hi);
        end
        checks++;
        if (log0.size() != n0 || log1.size() != n1) begin
            errors++;
            $display("FAIL hold_writes: %0d/%0d new writes, required 0", log0.size() - n0, log1.size() - n1);
        end
        checks++;
        if (bus_n.oOVF !== 1'b1 || bus_r.oOVF !== 1'b1) begin
            errors++;
            $display("FAIL hold_ovf: oOVF=%b/%b, required 1/1", bus_n.oOVF, bus_r.oOVF);
        end
        clear_logs();
        base = nstart[0];
        bus_n.iFHT_RDY = 1'b1;
        drive_frame(N, 1'b0);
        wait_start(base);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (log0[0].we !== 4'b0001 || log0[0].addr !== 8'd0 || log0[0].data !== sent[0]) begin
            errors++;
            $display("FAIL restart_first: we=%b addr=%0d data=%0d, required we=0001 addr=0 data=%0d",
                     log0[0].we, log0[0].addr, log0[0].data, sent[0]);
        end
        for (int d = 0; d < 2; d++) begin
            e = image_errs(d, N);
            checks++;
            if (e != 0) begin
                errors++;
                $display("FAIL image_restart dut%0d: %0d bad locations, required 0", d, e);
            end
        end
    endtask

    task automatic test_stale_ready();
        int ready_hi = 0;
        int busy_lo  = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus_n.oADC_READY || bus_r.oADC_READY) ready_hi++;
            if (!bus_n.oBUSY || !bus_r.oBUSY) busy_lo++;
        end
        checks++;
        if (ready_hi != 0 || busy_lo != 0) begin
            errors++;
            $display("FAIL stale_ready: ready-high %0d busy-low %0d cycles, required 0 and 0", ready_hi, busy_lo);
        end
        bus_n.iFHT_RDY = 1'b0;
        repeat (3) @(negedge clk);
        bus_n.iFHT_RDY = 1'b1;
        wait_ready();
    endtask

    task automatic test_abort();
        int base, e;
        clear_logs();
        base = nstart[0];
        drive_frame(300, 1'b0);
        bus_n.iEN = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (log0.size() != 300 || log1.size() != 300) begin
            errors++;
            $display("FAIL abort_writes: %0d/%0d, required 300", log0.size(), log1.size());
        end
        checks++;
        if (nstart[0] != base || nstart[1] != base) begin
            errors++;
            $display("FAIL abort_start: count %0d/%0d, required %0d", nstart[0], nstart[1], base);
        end
        checks++;
        if ({bus_n.oADC_READY, bus_n.oBUSY, bus_n.oOVF} !== 3'b000) begin
            errors++;
            $display("FAIL abort_flags: ready,busy,ovf=%b, required 000", {bus_n.oADC_READY, bus_n.oBUSY, bus_n.oOVF});
        end
        for (int d = 0; d < 2; d++) begin
            e = image_errs(d, 300);
            checks++;
            if (e != 0) begin
                errors++;
                $display("FAIL image_partial dut%0d: %0d bad locations, required 0", d, e);
            end
        end
        bus_n.iEN = 1'b1;
        clear_logs();
        drive_frame(N, 1'b0);
        wait_start(base);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (log1[0].we !== 4'b0001 || log1[0].addr !== 8'd0 || log1[0].data !== sent[0]) begin
            errors++;
            $display("FAIL abort_next_first: we=%b addr=%0d data=%0d, required we=0001 addr=0 data=%0d",
                     log1[0].we, log1[0].addr, log1[0].data, sent[0]);
        end
        checks++;
        if (nstart[0] != base + 1 || image_errs(0, N) != 0 || image_errs(1, N) != 0) begin
            errors++;
            $display("FAIL abort_next_frame: starts=%0d bad=%0d/%0d, required starts=%0d bad=0/0",
                     nstart[0], image_errs(0, N), image_errs(1, N), base + 1);
        end
    endtask

    task automatic test_async_reset();
        int          base;
        logic [30:0] obs_n, obs_r;
        repeat (3) begin
            @(negedge clk);
            bus_n.iADC_VALID = 1'b1;
        end
        @(negedge clk);
        bus_n.iADC_VALID = 1'b0;
        bus_n.iFHT_RDY   = 1'b0;
        repeat (2) @(negedge clk);
        bus_n.iFHT_RDY = 1'b1;
        wait_ready();
        clear_logs();
        base = nstart[0];
        drive_frame(700, 1'b0);
        #1;
        checks++;
        if (log0.size() != 700 || bus_n.oWE === 4'b0000 || bus_n.oOVF !== 1'b1 || bus_n.oBUSY !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: writes=%0d we=%b ovf=%b busy=%b, required 700 nonzero 1 1",
                     log0.size(), bus_n.oWE, bus_n.oOVF, bus_n.oBUSY);
        end
        rst_n = 1'b0;
        #1;
        obs_n = {bus_n.oADC_READY, bus_n.oWE, bus_n.oADDR_WR, bus_n.oDATA, bus_n.oSTART, bus_n.oBUSY, bus_n.oOVF};
        obs_r = {bus_r.oADC_READY, bus_r.oWE, bus_r.oADDR_WR, bus_r.oDATA, bus_r.oSTART, bus_r.oBUSY, bus_r.oOVF};
        checks++;
        if (obs_n !== 31'd0 || obs_r !== 31'd0) begin
            errors++;
            $display("FAIL async_reset: outputs=%h/%h, required 0/0", obs_n, obs_r);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        drive_frame(N, 1'b0);
        wait_start(base);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (log0[0].we !== 4'b0001 || log0[0].addr !== 8'd0 || nstart[0] != base + 1) begin
            errors++;
            $display("FAIL post_reset_first: we=%b addr=%0d starts=%0d, required we=0001 addr=0 starts=%0d",
                     log0[0].we, log0[0].addr, nstart[0], base + 1);
        end
        checks++;
        if (image_errs(0, N) != 0 || image_errs(1, N) != 0) begin
            errors++;
            $display("FAIL image_post_reset: bad=%0d/%0d, required 0/0", image_errs(0, N), image_errs(1, N));
        end
    endtask

    initial begin
        bus_n.iEN        = 1'b0;
        bus_n.iADC_DATA  = '0;
        bus_n.iADC_VALID = 1'b0;
        bus_n.iFHT_RDY   = 1'b0;
        for (int d = 0; d < 2; d++) begin
            nstart[d]      = 0;
            start_cyc[d]   = 0;
            last_we_cyc[d] = 0;
            bad_we[d]      = 0;
        end
        test_reset();
        test_natural_and_bitrev();
        test_handshake();
        test_stale_ready();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fht_adc_loader.md
Name: fht_adc_loader

Overview:
- Front-end stage directly upstream of fht_top.
- Accepts a stream of raw ADC samples (no bit expansion) and writes one N-point frame into fht_top's four input RAM banks via iDATA/iADDR_WR/iWE_0..3.
- Fires the one-cycle iSTART pulse, then holds off new writes until fht_top raises oRDY.
- Replaces the bench's hand-written bank loader and provides the frame-level handshake toward the ADC.

Parameters:
- ADC_BIT, 15, ADC sample width. Equals `D_BIT-1.
- A_BIT, 8, bank address width. Equals `A_BIT.
- N_POINT, 1024, points per frame. Must equal 4*2^A_BIT.
- BITREV, 0, 1 = write sample k at the bit-reversed index (log2(N_POINT) bits); 0 = natural order.

Ports:
- iCLK  in  1  system clock
- iRESET  in  1  asynchronous, active-low reset
- iEN  in  1  arm; while high the loader captures frames back-to-back
- iADC_DATA  in  ADC_BIT  signed ADC sample
- iADC_VALID  in  1  sample strobe, one sample per cycle max
- oADC_READY  out  1  high when a valid sample will be accepted
- oDATA  out  ADC_BIT  write data to fht_top iDATA
- oADDR_WR  out  A_BIT  write address to fht_top iADDR_WR
- oWE  out  4  bank write enables to iWE_0..iWE_3, one-hot or zero
- oSTART  out  1  one-cycle start pulse to fht_top iSTART
- iFHT_RDY  in  1  fht_top oRDY
- oBUSY  out  1  high from first accepted sample until FHT completion
- oOVF  out  1  sticky: a sample arrived while oADC_READY was low; cleared by reset or by iEN low

Behaviour:
- Reset (iRESET=0, async): state=IDLE, k=0; all outputs are 0.
- All outputs are registered.
- States:
  - IDLE: oADC_READY=0. If iEN=1, go to LOAD next cycle.
  - LOAD: oADC_READY=iEN. On iADC_VALID & oADC_READY:
    - p = BITREV ? rev(k) : k
    - next cycle: oWE[p[1:0]]=1, oADDR_WR=p[A_BIT+1:2], oDATA=iADC_DATA
    - k increments
    - Latency is one cycle from accepted sample to write strobe.
    - oWE=0 in every cycle without an accepted sample.
    - When k=N_POINT-1 is accepted, go to START. k wraps to 0.
  - START:
    - One gap cycle (last write completes, all oWE=0).
    - Next cycle: oSTART=1 for exactly one cycle, then go to WAIT.
    - This satisfies fht_top's requirement that iSTART follow the final write with no overlap.
  - WAIT: oADC_READY=0. iFHT_RDY is registered (rdy_q). On a rising edge (iFHT_RDY & ~rdy_q):
    - if iEN=1, go to LOAD
    - else go to IDLE
    - A level-high iFHT_RDY present at entry to WAIT, e.g. from the previous frame, is ignored.
- oBUSY=1 in LOAD after the first accepted sample, and in START and WAIT.
- Backpressure: iADC_VALID while oADC_READY=0 drops the sample (no write, k unchanged) and sets oOVF.
- iEN falling mid-LOAD:
  - oADC_READY drops the next cycle.
  - The partial frame is discarded: k=0, go to IDLE, no oSTART.
  - Bank contents are left as written.
- iEN falling in START or WAIT: the current FHT completes normally, then go to IDLE.
- Simultaneous last-sample accept and iEN fall: the sample is written, and START/WAIT proceed, since the frame is complete.
- Reset mid-frame: everything returns to reset values immediately; no oSTART is issued.

Decomposition:
- Package fht_loader_pkg holds:
  - state enum {IDLE, LOAD, START, WAIT}
  - localparam LOG2_N = $clog2(N_POINT)
  - bit-reverse function rev(k)
- Sub-module fht_bank_addr_gen holds the index-to-bank/address mapping: k and BITREV in, registered bank one-hot and address out.
- The FSM and handshake stay in the top module.

Test Plan:
- Natural order, BITREV=0, N=1024: stream samples k=0..1023 with data=k-512, one per cycle.
  - -> sample 5 writes bank 1, addr 1, oDATA=-507.
  - -> sample 1023 writes bank 3, addr 255.
  - -> exactly one oSTART, 2 cycles after the last oWE.
  - -> the RAM dump matches the matlab init_ram.txt layout.
- Bit-reverse, BITREV=1, N=1024:
  - -> sample 1 (rev=512) writes bank 0, addr 128.
  - -> sample 3 (rev=768) writes bank 0, addr 192.
  - -> all 1024 locations are written exactly once.
- Handshake: hold iFHT_RDY low 500 cycles after oSTART, keep iADC_VALID high.
  - -> oADC_READY=0 and no oWE during the wait.
  - -> oOVF=1.
  - -> the rising edge of iFHT_RDY restarts LOAD with first write at bank 0, addr 0.
- Stale ready: iFHT_RDY held high through the whole frame.
  - -> the loader stays in WAIT after oSTART until iFHT_RDY falls and rises again.
- Abort: drop iEN after 300 samples.
  - -> no oSTART.
  - -> next frame (iEN re-raised) writes its first sample at bank 0, addr 0.
- Async reset asserted mid-LOAD at sample 700, between clock edges.
  - -> oWE, oSTART, oBUSY and oOVF go to 0 immediately.
  - -> after release, the full frame loads from k=0.
